// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo
//   Output FIFO of a packet router. Each entry is stored as {header_flag,
//   data}. A read-side packet counter (pkt_cnt) tracks how many bytes of the
//   current packet are still to be read. When no packet is in progress and
//   nothing is read, dout drops to its idle value.
//
//   The header length field is din[WIDTH-1:2]. A packet occupies
//   1 header + length payload + 1 parity byte. Reading the header loads
//   pkt_cnt with length + 1, which covers the payload and the parity byte.
//
// Configuration macro:
//   ROUTER_FIFO_HIZ_EN
//     Defined   : dout is all-Z when idle. After rst, dout is 0.
//     Undefined : dout is 0 when idle. The block contains no tristate logic.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset; clears memory, pointers and
//              pkt_cnt, and sets dout to 0
//   soft_reset synchronous flush; zeroes the pointers and pkt_cnt, sets dout
//              to idle, leaves memory untouched
//   wr_en      write request
//   lfd_state  marks the current write word as a packet header
//   din        write data [WIDTH]
//   rd_en      read request
//   dout       registered read data [WIDTH], one cycle after the read
//   full       FIFO holds DEPTH entries (combinational)
//   empty      FIFO holds no entries (combinational)
// ---------------------------------------------------------------------------
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             wr_en,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [6:0]       pkt_cnt;
  logic [WIDTH-1:0] dout_q;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH:0]   rd_word;
  logic [WIDTH-3:0] rd_len;

  // The extra MSB on each pointer tells full and empty apart when the
  // index bits are equal.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign rd_len  = rd_word[WIDTH-1:2];

  // NOTE: the storage array is cleared by the hard reset, so it is built
  // from flops rather than a RAM macro. soft_reset does not clear it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!soft_reset && wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, din};
    end
  end

  // NOTE: all state is updated with non-blocking assignments, so every
  // branch below sees the pre-edge pointers and counter.
  always_ff @(posedge clk) begin
    if (!rst || soft_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_word[WIDTH])
          pkt_cnt <= 7'(rd_len) + 7'd1;
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - 7'd1;
      end
    end
  end

`ifdef ROUTER_FIFO_HIZ_EN
  // The idle state is carried by an output enable. dout_q only holds data,
  // so the flops never store Z.
  logic dout_oe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q  <= '0;
      dout_oe <= 1'b1;
    end else if (soft_reset) begin
      dout_oe <= 1'b0;
    end else if (rd_ok) begin
      dout_q  <= rd_word[WIDTH-1:0];
      dout_oe <= 1'b1;
    end else if (pkt_cnt == '0) begin
      dout_oe <= 1'b0;
    end
  end

  assign dout = dout_oe ? dout_q : {WIDTH{1'bz}};
`else
  always_ff @(posedge clk) begin
    if (!rst || soft_reset) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= rd_word[WIDTH-1:0];
    end else if (pkt_cnt == '0) begin
      dout_q <= '0;
    end
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// ---------------------------------------------------------------------------
// tb_router_fifo
//   Scoreboard bench for router_fifo using the default build (idle dout = 0).
//   Each accepted write is pushed into a model queue. Each accepted read pops
//   the queue and predicts dout, which is compared one cycle later. A small
//   packet-counter model predicts when dout returns to idle.
// ---------------------------------------------------------------------------
module tb_router_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic       lfd;
    logic [7:0] data;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             soft_reset;
  logic             wr_en;
  logic             lfd_state;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;

  entry_t     q[$];
  logic [7:0] exp_dout = '0;
  logic [6:0] m_pkt    = '0;
  logic [4:0] m_rd     = '0;
  int         n_cmp    = 0;
  int         n_bad    = 0;

  router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .wr_en      (wr_en),
    .lfd_state  (lfd_state),
    .din        (din),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one clock with the given inputs and checks dout/empty/full against
  // the model. Inputs change #1 after a rising edge.
  task automatic step(input logic w, input logic l, input logic [7:0] d,
                      input logic r);
    logic   w_acc;
    logic   r_acc;
    entry_t e;
    wr_en     = w;
    lfd_state = l;
    din       = d;
    rd_en     = r;
    w_acc     = w && (q.size() < DEPTH);
    r_acc     = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (r_acc) begin
      e        = q.pop_front();
      exp_dout = e.data;
      if (e.lfd)            m_pkt = 7'(e.data[7:2]) + 7'd1;
      else if (m_pkt != 0)  m_pkt = m_pkt - 7'd1;
      m_rd = m_rd + 5'd1;
    end else if (m_pkt == 0) begin
      exp_dout = '0;
    end
    if (w_acc) q.push_back({l, d});
    check("dout",  dout,  exp_dout);
    check("empty", empty, q.size() == 0);
    check("full",  full,  q.size() == DEPTH);
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic pulse_soft_reset();
    soft_reset = 1'b1;
    wr_en      = 1'b1;
    rd_en      = 1'b1;
    din        = 8'hEE;
    @(posedge clk);
    #1;
    soft_reset = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    q.delete();
    m_pkt    = '0;
    m_rd     = '0;
    exp_dout = '0;
    check("soft_empty", empty, 1);
    check("soft_full",  full,  0);
    check("soft_dout",  dout,  0);
  endtask

  initial begin
    logic [7:0] pkt[5];
    pkt = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};

    // Reset held two cycles with a write pending: nothing is stored.
    rst = 1'b0; soft_reset = 1'b0; wr_en = 1'b1; lfd_state = 1'b0;
    din = 8'h55; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);
    check("rst_dout",  dout,  0);
    rst = 1'b1; wr_en = 1'b0;
    step(0, 0, 8'h00, 0);

    // Packet pass-through.
    for (int i = 0; i < 5; i++) step(1, i == 0, pkt[i], 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
    check("pkt_cnt_end", dut.pkt_cnt, 0);
    step(0, 0, 8'h00, 0);

    // Full boundary: 16 writes, a dropped 17th, then drain.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i * 7 + 3), 0);
    step(1, 0, 8'hFF, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Read while empty: rd_ptr stays put, dout idle, still empty.
    step(0, 0, 8'h00, 1);
    check("rd_ptr_hold", dut.rd_ptr, m_rd);

    // Wrap with simultaneous read/write at 15 entries.
    for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 8'(8'h40 + i), 0);
    for (int i = 0; i < 40; i++) step(1, 0, 8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Soft reset mid-packet.
    step(1, 1, 8'h28, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hB0 + i), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    pulse_soft_reset();
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h0C, 0);
    step(1, 0, 8'hC1, 0);
    step(0, 0, 8'h00, 1);
    check("pkt_cnt_new_hdr", dut.pkt_cnt, 4);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
